// File: rtl/sd_controller_wb.sv
// ---------------------------------------------------------------------------
// sd_controller_wb
// Wishbone B3 slave register file for the SD card controller. Holds the
// host-programmable configuration (command, argument, timeouts, clock
// divider, block size/count, DMA address, interrupt enables), returns the
// command/data engine responses and interrupt status, and generates
// one-cycle strobes for command start and interrupt clears.
//
// Ports:
//   wb_clk_i, wb_rst_i (sync, active-low)     clock / reset
//   wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i,    Wishbone request
//   wb_cyc_i, wb_stb_i
//   wb_dat_o, wb_ack_o                         Wishbone response
//   cmd_start, cmd_int_rst, data_int_rst       one-cycle strobes
//   *_reg outputs                              configuration registers
//   response_*_reg, *_int_status_reg inputs    engine status for readback
//
// Handshake: a request is valid while cyc & stb are high; the slave
// accepts it on the first edge where ack is low (access = cyc & stb & ~ack)
// and answers with a single-cycle registered ack on the following cycle,
// with wb_dat_o valid while ack is high. The master drops stb on ack, so
// every request is acknowledged exactly once.
// ---------------------------------------------------------------------------
module sd_controller_wb #(
   parameter int CMD_REG_SIZE      = 14,
   parameter int CMD_TIMEOUT_W     = 24,
   parameter int DATA_TIMEOUT_W    = 24,
   parameter int BLKSIZE_W         = 12,
   parameter int BLKCNT_W          = 16,
   parameter int INT_CMD_SIZE      = 5,
   parameter int INT_DATA_SIZE     = 3,
   parameter int RESET_BLOCK_SIZE  = 511,
   parameter int RESET_CLK_DIV     = 0,
   parameter int SUPPLY_VOLTAGE_mV = 3300
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [31:0]               wb_dat_i,
   output logic [31:0]               wb_dat_o,
   input  logic [7:0]                wb_adr_i,
   input  logic [3:0]                wb_sel_i,
   input  logic                      wb_we_i,
   input  logic                      wb_cyc_i,
   input  logic                      wb_stb_i,
   output logic                      wb_ack_o,
   output logic                      cmd_start,
   output logic                      data_int_rst,
   output logic                      cmd_int_rst,
   output logic [31:0]               argument_reg,
   output logic [CMD_REG_SIZE-1:0]   command_reg,
   input  logic [31:0]               response_0_reg,
   input  logic [31:0]               response_1_reg,
   input  logic [31:0]               response_2_reg,
   input  logic [31:0]               response_3_reg,
   output logic                      software_reset_reg,
   output logic [CMD_TIMEOUT_W-1:0]  cmd_timeout_reg,
   output logic [DATA_TIMEOUT_W-1:0] data_timeout_reg,
   output logic [BLKSIZE_W-1:0]      block_size_reg,
   output logic                      controll_setting_reg,
   input  logic [INT_CMD_SIZE-1:0]   cmd_int_status_reg,
   output logic [INT_CMD_SIZE-1:0]   cmd_int_enable_reg,
   output logic [7:0]                clock_divider_reg,
   output logic [BLKCNT_W-1:0]       block_count_reg,
   output logic [31:0]               dma_addr_reg,
   input  logic [INT_DATA_SIZE-1:0]  data_int_status_reg,
   output logic [INT_DATA_SIZE-1:0]  data_int_enable_reg
);

   localparam logic [7:0] ADR_ARGUMENT     = 8'h00;
   localparam logic [7:0] ADR_COMMAND      = 8'h04;
   localparam logic [7:0] ADR_RESP0        = 8'h08;
   localparam logic [7:0] ADR_RESP1        = 8'h0C;
   localparam logic [7:0] ADR_RESP2        = 8'h10;
   localparam logic [7:0] ADR_RESP3        = 8'h14;
   localparam logic [7:0] ADR_DATA_TIMEOUT = 8'h18;
   localparam logic [7:0] ADR_CONTROLLER   = 8'h1C;
   localparam logic [7:0] ADR_CMD_TIMEOUT  = 8'h20;
   localparam logic [7:0] ADR_CLOCK_D      = 8'h24;
   localparam logic [7:0] ADR_RESET        = 8'h28;
   localparam logic [7:0] ADR_VOLTAGE      = 8'h2C;
   localparam logic [7:0] ADR_CAPA         = 8'h30;
   localparam logic [7:0] ADR_CMD_ISR      = 8'h34;
   localparam logic [7:0] ADR_CMD_ISER     = 8'h38;
   localparam logic [7:0] ADR_DATA_ISR     = 8'h3C;
   localparam logic [7:0] ADR_DATA_ISER    = 8'h40;
   localparam logic [7:0] ADR_BLKSIZE      = 8'h44;
   localparam logic [7:0] ADR_BLKCNT       = 8'h48;
   localparam logic [7:0] ADR_DST_SRC_ADDR = 8'h60;

   logic        access;
   logic        wr;
   logic [31:0] rd_data;

   assign access = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr     = access & wb_we_i;

   // Byte-lane merge on a 32-bit view; narrow registers zero-extend their
   // current value in and truncate the result, so absent lanes are dropped.
   function automatic logic [31:0] merge(input logic [31:0] cur,
                                         input logic [31:0] dat,
                                         input logic [3:0]  sel);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) res[8*i +: 8] = dat[8*i +: 8];
      end
      return res;
   endfunction

   always_comb begin
      rd_data = 32'h0;
      case (wb_adr_i)
         ADR_ARGUMENT:     rd_data = argument_reg;
         ADR_COMMAND:      rd_data = 32'(command_reg);
         ADR_RESP0:        rd_data = response_0_reg;
         ADR_RESP1:        rd_data = response_1_reg;
         ADR_RESP2:        rd_data = response_2_reg;
         ADR_RESP3:        rd_data = response_3_reg;
         ADR_DATA_TIMEOUT: rd_data = 32'(data_timeout_reg);
         ADR_CONTROLLER:   rd_data = 32'(controll_setting_reg);
         ADR_CMD_TIMEOUT:  rd_data = 32'(cmd_timeout_reg);
         ADR_CLOCK_D:      rd_data = 32'(clock_divider_reg);
         ADR_RESET:        rd_data = 32'(software_reset_reg);
         ADR_VOLTAGE:      rd_data = 32'(SUPPLY_VOLTAGE_mV);
         ADR_CAPA:         rd_data = 32'h0;
         ADR_CMD_ISR:      rd_data = 32'(cmd_int_status_reg);
         ADR_CMD_ISER:     rd_data = 32'(cmd_int_enable_reg);
         ADR_DATA_ISR:     rd_data = 32'(data_int_status_reg);
         ADR_DATA_ISER:    rd_data = 32'(data_int_enable_reg);
         ADR_BLKSIZE:      rd_data = 32'(block_size_reg);
         ADR_BLKCNT:       rd_data = 32'(block_count_reg);
         ADR_DST_SRC_ADDR: rd_data = dma_addr_reg;
         default:          rd_data = 32'h0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         wb_ack_o             <= 1'b0;
         wb_dat_o             <= 32'h0;
         cmd_start            <= 1'b0;
         cmd_int_rst          <= 1'b0;
         data_int_rst         <= 1'b0;
         argument_reg         <= 32'h0;
         command_reg          <= '0;
         software_reset_reg   <= 1'b0;
         cmd_timeout_reg      <= '0;
         data_timeout_reg     <= '0;
         block_size_reg       <= BLKSIZE_W'(RESET_BLOCK_SIZE);
         controll_setting_reg <= 1'b0;
         cmd_int_enable_reg   <= '0;
         clock_divider_reg    <= 8'(RESET_CLK_DIV);
         block_count_reg      <= '0;
         dma_addr_reg         <= 32'h0;
         data_int_enable_reg  <= '0;
      end else begin
         wb_ack_o     <= access;
         cmd_start    <= 1'b0;
         cmd_int_rst  <= 1'b0;
         data_int_rst <= 1'b0;
         // Read data is captured on every access so it lines up with ack,
         // and is held until the next access.
         if (access) wb_dat_o <= rd_data;
         if (wr) begin
            case (wb_adr_i)
               ADR_ARGUMENT: begin
                  argument_reg <= merge(argument_reg, wb_dat_i, wb_sel_i);
                  cmd_start    <= 1'b1;
               end
               ADR_COMMAND:
                  command_reg <= CMD_REG_SIZE'(merge(32'(command_reg), wb_dat_i, wb_sel_i));
               ADR_DATA_TIMEOUT:
                  data_timeout_reg <= DATA_TIMEOUT_W'(merge(32'(data_timeout_reg), wb_dat_i, wb_sel_i));
               ADR_CONTROLLER:
                  controll_setting_reg <= 1'(merge(32'(controll_setting_reg), wb_dat_i, wb_sel_i));
               ADR_CMD_TIMEOUT:
                  cmd_timeout_reg <= CMD_TIMEOUT_W'(merge(32'(cmd_timeout_reg), wb_dat_i, wb_sel_i));
               ADR_CLOCK_D:
                  clock_divider_reg <= 8'(merge(32'(clock_divider_reg), wb_dat_i, wb_sel_i));
               ADR_RESET:
                  software_reset_reg <= 1'(merge(32'(software_reset_reg), wb_dat_i, wb_sel_i));
               ADR_CMD_ISR:
                  cmd_int_rst <= 1'b1;
               ADR_CMD_ISER:
                  cmd_int_enable_reg <= INT_CMD_SIZE'(merge(32'(cmd_int_enable_reg), wb_dat_i, wb_sel_i));
               ADR_DATA_ISR:
                  data_int_rst <= 1'b1;
               ADR_DATA_ISER:
                  data_int_enable_reg <= INT_DATA_SIZE'(merge(32'(data_int_enable_reg), wb_dat_i, wb_sel_i));
               ADR_BLKSIZE:
                  block_size_reg <= BLKSIZE_W'(merge(32'(block_size_reg), wb_dat_i, wb_sel_i));
               ADR_BLKCNT:
                  block_count_reg <= BLKCNT_W'(merge(32'(block_count_reg), wb_dat_i, wb_sel_i));
               ADR_DST_SRC_ADDR:
                  dma_addr_reg <= merge(dma_addr_reg, wb_dat_i, wb_sel_i);
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_controller_wb.sv
// ---------------------------------------------------------------------------
// tb_sd_controller_wb
// Directed bench for sd_controller_wb: reset values, register writes,
// readback of engine status, strobes and byte-lane enables.
// ---------------------------------------------------------------------------
module tb_sd_controller_wb;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b0;
   logic [31:0] wb_dat_i = 32'h0;
   logic [31:0] wb_dat_o;
   logic [7:0]  wb_adr_i = 8'h0;
   logic [3:0]  wb_sel_i = 4'h0;
   logic        wb_we_i  = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic        wb_ack_o;
   logic        cmd_start, data_int_rst, cmd_int_rst;
   logic [31:0] argument_reg;
   logic [13:0] command_reg;
   logic [31:0] response_0_reg = 32'h0;
   logic [31:0] response_1_reg = 32'h0;
   logic [31:0] response_2_reg = 32'h0;
   logic [31:0] response_3_reg = 32'h0;
   logic        software_reset_reg;
   logic [23:0] cmd_timeout_reg;
   logic [23:0] data_timeout_reg;
   logic [11:0] block_size_reg;
   logic        controll_setting_reg;
   logic [4:0]  cmd_int_status_reg = 5'h0;
   logic [4:0]  cmd_int_enable_reg;
   logic [7:0]  clock_divider_reg;
   logic [15:0] block_count_reg;
   logic [31:0] dma_addr_reg;
   logic [2:0]  data_int_status_reg = 3'h0;
   logic [2:0]  data_int_enable_reg;

   sd_controller_wb dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
      .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_ack_o(wb_ack_o),
      .cmd_start(cmd_start), .data_int_rst(data_int_rst), .cmd_int_rst(cmd_int_rst),
      .argument_reg(argument_reg), .command_reg(command_reg),
      .response_0_reg(response_0_reg), .response_1_reg(response_1_reg),
      .response_2_reg(response_2_reg), .response_3_reg(response_3_reg),
      .software_reset_reg(software_reset_reg),
      .cmd_timeout_reg(cmd_timeout_reg), .data_timeout_reg(data_timeout_reg),
      .block_size_reg(block_size_reg), .controll_setting_reg(controll_setting_reg),
      .cmd_int_status_reg(cmd_int_status_reg), .cmd_int_enable_reg(cmd_int_enable_reg),
      .clock_divider_reg(clock_divider_reg), .block_count_reg(block_count_reg),
      .dma_addr_reg(dma_addr_reg),
      .data_int_status_reg(data_int_status_reg), .data_int_enable_reg(data_int_enable_reg)
   );

   // ---------------- clock / reset ----------------
   always #5 wb_clk_i = ~wb_clk_i;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Values captured by the driver around each transfer.
   logic [2:0]  strb_at_ack;    // {cmd_start, cmd_int_rst, data_int_rst} while ack=1
   logic [2:0]  strb_after;     // same, one cycle later
   logic        ack_after;      // ack one cycle after the acknowledged cycle
   logic [31:0] dat_after;      // wb_dat_o one cycle after ack

   // ---------------- driver tasks ----------------
   task automatic wb_xfer(input logic [7:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we,
                          output logic [31:0] rdat);
      int n;
      @(posedge wb_clk_i); #1;
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      n = 0;
      do begin
         @(posedge wb_clk_i); #1;
         n++;
      end while (!wb_ack_o && n < 10);
      check($sformatf("ack_seen@%02h", adr), 32'(wb_ack_o), 32'd1);
      rdat        = wb_dat_o;
      strb_at_ack = {cmd_start, cmd_int_rst, data_int_rst};
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      @(posedge wb_clk_i); #1;
      ack_after  = wb_ack_o;
      strb_after = {cmd_start, cmd_int_rst, data_int_rst};
      dat_after  = wb_dat_o;
   endtask

   task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] unused;
      wb_xfer(adr, dat, sel, 1'b1, unused);
   endtask

   task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat);
      wb_xfer(adr, 32'h0, 4'hF, 1'b0, dat);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic [31:0] rd;
      logic [7:0]  rd_adr[10];

      // Reset held low for 3 cycles.
      wb_rst_i = 1'b0;
      repeat (3) @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      check("rst_ack",        32'(wb_ack_o), 32'h0);
      check("rst_dat_o",      wb_dat_o, 32'h0);
      check("rst_strobes",    32'({cmd_start, cmd_int_rst, data_int_rst}), 32'h0);
      check("rst_argument",   argument_reg, 32'h0);
      check("rst_command",    32'(command_reg), 32'h0);
      check("rst_blksize",    32'(block_size_reg), 32'd511);
      check("rst_clkdiv",     32'(clock_divider_reg), 32'h0);
      check("rst_blkcnt",     32'(block_count_reg), 32'h0);
      check("rst_dma",        dma_addr_reg, 32'h0);
      check("rst_misc",       32'({software_reset_reg, controll_setting_reg,
                                   cmd_int_enable_reg, data_int_enable_reg}), 32'h0);
      check("rst_timeouts",   32'(cmd_timeout_reg | data_timeout_reg), 32'h0);

      // Argument write: cmd_start pulses with ack for one cycle only.
      wb_write(8'h00, 32'h01020304, 4'hF);
      check("arg_value",      argument_reg, 32'h01020304);
      check("arg_cmd_start",  32'(strb_at_ack), 32'b100);
      check("arg_strb_after", 32'(strb_after), 32'b000);
      check("arg_ack_single", 32'(ack_after), 32'h0);
      check("arg_cmd_keep",   32'(command_reg), 32'h0);

      // Configuration writes.
      wb_write(8'h04, 32'h0405, 4'hF);
      check("command",       32'(command_reg), 32'h0405);
      check("cmd_no_start",  32'(strb_at_ack), 32'b000);
      wb_write(8'h1C, 32'h1, 4'hF);       check("controller", 32'(controll_setting_reg), 32'h1);
      wb_write(8'h20, 32'h0B0C, 4'hF);    check("cmd_timeout", 32'(cmd_timeout_reg), 32'h0B0C);
      wb_write(8'h18, 32'h0C0B, 4'hF);    check("data_timeout", 32'(data_timeout_reg), 32'h0C0B);
      wb_write(8'h24, 32'h0D, 4'hF);      check("clock_div", 32'(clock_divider_reg), 32'h0D);
      wb_write(8'h28, 32'h1, 4'hF);       check("sw_reset", 32'(software_reset_reg), 32'h1);
      wb_write(8'h38, 32'h15, 4'hF);      check("cmd_iser", 32'(cmd_int_enable_reg), 32'h15);
      wb_write(8'h40, 32'h5, 4'hF);       check("data_iser", 32'(data_int_enable_reg), 32'h5);
      wb_write(8'h44, 32'hABC, 4'hF);     check("blksize", 32'(block_size_reg), 32'hABC);
      wb_write(8'h48, 32'h1011, 4'hF);    check("blkcnt", 32'(block_count_reg), 32'h1011);
      wb_write(8'h60, 32'h11121314, 4'hF); check("dma_addr", dma_addr_reg, 32'h11121314);

      // Unmapped and read-only writes change nothing and raise no strobe.
      wb_write(8'h4C, 32'hDEADBEEF, 4'hF);
      check("unmapped_wr_dma", dma_addr_reg, 32'h11121314);
      check("unmapped_wr_arg", argument_reg, 32'h01020304);
      wb_write(8'h08, 32'hDEADBEEF, 4'hF);
      check("ro_wr_no_strobe", 32'(strb_at_ack), 32'b000);

      // Readback of engine inputs, constants, RW registers and unmapped space.
      response_0_reg = 32'h04050607; response_1_reg = 32'h05060708;
      response_2_reg = 32'h06070809; response_3_reg = 32'h0708090A;
      cmd_int_status_reg = 5'h1A;    data_int_status_reg = 3'h6;
      rd_adr = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h34, 8'h3C, 8'h2C, 8'h30, 8'h04, 8'h50};
      exp_q.push_back(32'h04050607); exp_q.push_back(32'h05060708);
      exp_q.push_back(32'h06070809); exp_q.push_back(32'h0708090A);
      exp_q.push_back(32'h0000001A); exp_q.push_back(32'h00000006);
      exp_q.push_back(32'd3300);     exp_q.push_back(32'h0);
      exp_q.push_back(32'h00000405); exp_q.push_back(32'h0);
      for (int i = 0; i < 10; i++) begin
         wb_read(rd_adr[i], rd);
         check($sformatf("read@%02h", rd_adr[i]), rd, exp_q.pop_front());
      end
      wb_read(8'h0C, rd);
      check("dat_o_hold", dat_after, 32'h05060708);

      // Interrupt clear strobes.
      wb_write(8'h34, 32'h0, 4'h0);
      check("cmd_int_rst_pulse", 32'(strb_at_ack), 32'b010);
      check("cmd_int_rst_after", 32'(strb_after), 32'b000);
      wb_write(8'h3C, 32'h0, 4'h0);
      check("data_int_rst_pulse", 32'(strb_at_ack), 32'b001);
      check("data_int_rst_after", 32'(strb_after), 32'b000);

      // Byte-lane enables.
      wb_write(8'h60, 32'hFFFFFFFF, 4'hF);
      wb_write(8'h60, 32'h01020304, 4'h1);
      check("sel_dma", dma_addr_reg, 32'hFFFFFF04);
      wb_write(8'h48, 32'hFFFF, 4'hF);
      wb_write(8'h48, 32'h0, 4'h2);
      check("sel_blkcnt", 32'(block_count_reg), 32'h00FF);
      wb_write(8'h04, 32'h00FF0000, 4'h4);
      check("sel_absent_lane", 32'(command_reg), 32'h0405);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/sd_controller_wb.md
Name: sd_controller_wb

Overview:
- Wishbone B3 slave register file for the SD card controller.
- Holds host-programmable configuration registers: command, argument, timeouts, clock divider, block size/count, DMA address and interrupt enables.
- Exposes the command/data engine's responses and interrupt status for readback.
- Generates one-cycle strobes: command start, cmd interrupt clear, data interrupt clear.

Parameters:
- CMD_REG_SIZE, 14, command register width
- CMD_TIMEOUT_W, 24, command timeout width
- DATA_TIMEOUT_W, 24, data timeout width
- BLKSIZE_W, 12, block size width
- BLKCNT_W, 16, block count width
- INT_CMD_SIZE, 5, cmd interrupt status/enable width
- INT_DATA_SIZE, 3, data interrupt status/enable width
- RESET_BLOCK_SIZE, 511, block_size_reg reset value
- RESET_CLK_DIV, 0, clock_divider_reg reset value
- SUPPLY_VOLTAGE_mV, 3300, constant returned by the voltage register

Ports:
- wb_clk_i in 1: the block's single clock; all logic is on its rising edge.
- wb_rst_i in 1: reset, synchronous, active-low.
- wb_dat_i in 32 / wb_dat_o out 32: write data / read data.
- wb_adr_i in 8: byte address. wb_sel_i in 4: byte lane enables.
- wb_we_i, wb_cyc_i, wb_stb_i in 1: Wishbone controls. wb_ack_o out 1: acknowledge.
- cmd_start out 1: pulse on argument write. data_int_rst out 1 / cmd_int_rst out 1: pulse on data_isr / cmd_isr write.
- argument_reg out 32; command_reg out CMD_REG_SIZE.
- response_0_reg..response_3_reg in 32 each: response words from the cmd engine.
- software_reset_reg out 1; cmd_timeout_reg out CMD_TIMEOUT_W; data_timeout_reg out DATA_TIMEOUT_W; block_size_reg out BLKSIZE_W; controll_setting_reg out 1.
- cmd_int_status_reg in INT_CMD_SIZE; cmd_int_enable_reg out INT_CMD_SIZE.
- clock_divider_reg out 8; block_count_reg out BLKCNT_W; dma_addr_reg out 32.
- data_int_status_reg in INT_DATA_SIZE; data_int_enable_reg out INT_DATA_SIZE.

Behaviour:
- Address map:
  - 0x00 argument RW; 0x04 command RW
  - 0x08/0x0C/0x10/0x14 resp0..3 RO
  - 0x18 data_timeout RW; 0x1C controller RW; 0x20 cmd_timeout RW; 0x24 clock_d RW; 0x28 reset RW
  - 0x2C voltage RO (=SUPPLY_VOLTAGE_mV); 0x30 capa RO (=0)
  - 0x34 cmd_isr (read status / write clears); 0x38 cmd_iser RW
  - 0x3C data_isr (read status / write clears); 0x40 data_iser RW
  - 0x44 blksize RW; 0x48 blkcnt RW; 0x60 dst_src_addr RW
  - Unmapped: reads 0, writes ignored.
- Handshake:
  - access = cyc & stb & ~ack.
  - ack is registered: ack <= access, i.e. a one-cycle pulse in the cycle after the request is sampled.
  - Master drops stb on ack. ack is never asserted two consecutive cycles; every access is acknowledged exactly once.
- Write: on the edge where access & we, each byte lane i with sel[i]=1 updates bits [8i+7:8i] of the target register. Only bits existing in the register are updated; unselected lanes keep their value.
- Read:
  - wb_dat_o is registered on the same edge as ack, so it is valid while ack=1.
  - Value is the register/input zero-extended to 32 bits; RW registers read back their current value.
  - wb_dat_o holds its value between accesses.
- Strobes:
  - cmd_start goes 1 for exactly one cycle, registered with the argument update (visible together with ack).
  - cmd_int_rst / data_int_rst behave the same on any write to 0x34 / 0x3C, whatever the data or sel.
  - Writes to RO registers produce no strobe.
- Reset (wb_rst_i=0 at a clock edge):
  - All outputs 0, except block_size_reg=RESET_BLOCK_SIZE and clock_divider_reg=RESET_CLK_DIV.
  - ack=0, strobes=0, wb_dat_o=0.
  - Reset mid-access aborts it: no ack, no register update.
- software_reset_reg is only a stored bit; it does not reset this block.

Test Plan:
- Hold reset low 3 cycles, release -> all outputs 0 except block_size_reg=511 and clock_divider_reg=0; ack=0.
- Write 0x01020304 to 0x00 with sel=F -> argument_reg=0x01020304; cmd_start high one cycle only; command_reg unchanged; ack single-cycle.
- Write command 0x0405, controller 1, cmd_timeout 0x0B0C, data_timeout 0x0C0B, clock_d 0x0D, reset 1, cmd_iser 0x15, data_iser 0x5, blksize 0xABC, blkcnt 0x1011, dst_src_addr 0x11121314 -> each output equals the written value.
- Drive response_0..3 = 0x04050607/0x05060708/0x06070809/0x0708090A, cmd_int_status=0x1A, data_int_status=0x6 -> reads of 0x08..0x14, 0x34, 0x3C return them. Voltage read returns 3300; capa read returns 0.
- Write to 0x34 then 0x3C -> cmd_int_rst then data_int_rst each pulse for one cycle.
- Byte select:
  - dst_src_addr=0xFFFFFFFF, then write 0x01020304 with sel=1 -> 0xFFFFFF04.
  - blkcnt=0xFFFF, then write 0 with sel=2 -> 0x00FF.
